// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC and IF/ID register, assembling two-word instructions.
// Optional FETCH_PERF_EN adds instruction/bubble counters.
module fetch_stage #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 16,
  parameter int IMEM_AW = 21,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_imm,
  output logic               if_id_has_imm,
  output logic [PC_W-1:0]    if_id_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_instr_cnt,
  output logic [31:0]        perf_bubble_cnt,
`endif
  output logic [PC_W-1:0]    if_id_pc_next
);
  typedef enum logic {S_OP, S_IMM} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc, pc_n, pc_inc, op_pc, op_pc_n;
  logic [INSTR_W-1:0] op_instr, op_instr_n;
  logic valid_n, has_imm_n, hold, load, is_long;
  logic [INSTR_W-1:0] instr_n, imm_n;
  logic [PC_W-1:0] id_pc_n, id_pc_next_n;
  assign imem_addr = pc[IMEM_AW-1:0];
  assign pc_inc = pc + 1'b1;
  assign is_long = imem_data[INSTR_W-1];
  assign hold = stall & ~redirect_valid & ~flush;
  assign load = ~redirect_valid & ~flush & ~stall;
  always_ff @(posedge clk)
    if (!reset) state <= S_OP;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (redirect_valid) state_n = S_OP;
    else if (flush) state_n = S_OP;
    else if (!stall) state_n = (state == S_OP && is_long) ? S_IMM : S_OP;
  end
  // The IMM word is never decoded: only the S_OP path looks at bit 15.
  always_comb begin
    pc_n = pc;
    op_pc_n = op_pc;
    op_instr_n = op_instr;
    valid_n = if_id_valid;
    instr_n = if_id_instr;
    imm_n = if_id_imm;
    has_imm_n = if_id_has_imm;
    id_pc_n = if_id_pc;
    id_pc_next_n = if_id_pc_next;
    if (redirect_valid) begin
      pc_n = redirect_pc;
      valid_n = 1'b0;
    end else if (flush) begin
      pc_n = (state == S_IMM) ? op_pc : pc;
      valid_n = 1'b0;
    end else if (load) begin
      pc_n = pc_inc;
      if (state == S_OP && is_long) begin
        op_pc_n = pc;
        op_instr_n = imem_data;
        valid_n = 1'b0;
      end else begin
        valid_n = 1'b1;
        instr_n = (state == S_IMM) ? op_instr : imem_data;
        imm_n = (state == S_IMM) ? imem_data : '0;
        has_imm_n = state == S_IMM;
        id_pc_n = (state == S_IMM) ? op_pc : pc;
        id_pc_next_n = pc_inc;
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      pc <= RESET_PC;
      op_pc <= '0;
      op_instr <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
      if_id_imm <= '0;
      if_id_has_imm <= 1'b0;
      if_id_pc <= '0;
      if_id_pc_next <= '0;
    end else begin
      pc <= pc_n;
      op_pc <= op_pc_n;
      op_instr <= op_instr_n;
      if_id_valid <= valid_n;
      if_id_instr <= instr_n;
      if_id_imm <= imm_n;
      if_id_has_imm <= has_imm_n;
      if_id_pc <= id_pc_n;
      if_id_pc_next <= id_pc_next_n;
    end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk)
    if (!reset) begin
      perf_instr_cnt <= '0;
      perf_bubble_cnt <= '0;
    end else if (!hold) begin
      perf_instr_cnt <= perf_instr_cnt + {31'd0, valid_n};
      perf_bubble_cnt <= perf_bubble_cnt + {31'd0, ~valid_n};
    end
`else
  logic unused;
  assign unused = hold;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage against a small behavioural instruction memory.
module tb_fetch_stage;
  logic clk = 0, reset = 0, stall = 0, flush = 0, redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic [20:0] imem_addr;
  logic [15:0] imem_data;
  logic if_id_valid, if_id_has_imm;
  logic [15:0] if_id_instr, if_id_imm;
  logic [31:0] if_id_pc, if_id_pc_next;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_instr_cnt, perf_bubble_cnt;
`endif
  logic [15:0] mem [0:255];
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[7:0]];
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_imm(if_id_imm),
    .if_id_has_imm(if_id_has_imm), .if_id_pc(if_id_pc),
`ifdef FETCH_PERF_EN
    .perf_instr_cnt(perf_instr_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
    .if_id_pc_next(if_id_pc_next)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_id(input string tag, input logic v, input logic [15:0] ins, input logic [15:0] imm,
                          input logic h, input logic [31:0] p, input logic [31:0] pn);
    check({tag, ".valid"}, 64'(if_id_valid), 64'(v));
    check({tag, ".instr"}, 64'(if_id_instr), 64'(ins));
    check({tag, ".imm"}, 64'(if_id_imm), 64'(imm));
    check({tag, ".has_imm"}, 64'(if_id_has_imm), 64'(h));
    check({tag, ".pc"}, 64'(if_id_pc), 64'(p));
    check({tag, ".pc_next"}, 64'(if_id_pc_next), 64'(pn));
  endtask
  initial begin
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h0033; mem[3] = 16'h0044;
    mem[4] = 16'h8123; mem[5] = 16'hBEEF; mem[6] = 16'h0066;
    mem[8] = 16'h8AAA; mem[9] = 16'h1234; mem[10] = 16'h00AA;
    mem[8'h40] = 16'h0440; mem[8'h41] = 16'h0441; mem[255] = 16'h0055;
    tick(); tick();
    check("rst.addr", 64'(imem_addr), 0);
    check_id("rst", 0, 0, 0, 0, 0, 0);
    reset = 1;
    tick(); check_id("t1a", 1, 16'h0011, 0, 0, 0, 1);
    tick(); check_id("t1b", 1, 16'h0022, 0, 0, 1, 2);
    check("t3.addr_pre", 64'(imem_addr), 2);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3.addr", 64'(imem_addr), 2);
      check_id("t3.hold", 1, 16'h0022, 0, 0, 1, 2);
    end
    stall = 0;
    tick(); check_id("t1c", 1, 16'h0033, 0, 0, 2, 3);
    tick(); check_id("short3", 1, 16'h0044, 0, 0, 3, 4);
    tick();
    check("t2.bubble", 64'(if_id_valid), 0);
    check("t2.addr", 64'(imem_addr), 5);
    tick(); check_id("t2", 1, 16'h8123, 16'hBEEF, 1, 4, 6);
    redirect_valid = 1; redirect_pc = 8;
    tick(); check("t5.redir", 64'(if_id_valid), 0); check("t5.addr8", 64'(imem_addr), 8);
    redirect_valid = 0;
    tick(); check("t5.simm", 64'(imem_addr), 9); check("t5.bub", 64'(if_id_valid), 0);
    flush = 1;
    tick(); check("t5.flush_v", 64'(if_id_valid), 0); check("t5.flush_pc", 64'(imem_addr), 8);
    flush = 0;
    tick(); check("t5.refetch", 64'(imem_addr), 9); check("t5.bub2", 64'(if_id_valid), 0);
    tick(); check_id("t5", 1, 16'h8AAA, 16'h1234, 1, 8, 10);
    flush = 1;
    tick(); check("fop.v", 64'(if_id_valid), 0); check("fop.pc", 64'(imem_addr), 10);
    check("fop.instr", 64'(if_id_instr), 16'h8AAA);
    flush = 0;
    redirect_valid = 1; stall = 1; redirect_pc = 32'h40;
    tick(); check("t4.addr", 64'(imem_addr), 32'h40); check("t4.v", 64'(if_id_valid), 0);
    redirect_valid = 0; stall = 0;
    tick(); check_id("t4", 1, 16'h0440, 0, 0, 32'h40, 32'h41);
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    tick(); check("t6.addr", 64'(imem_addr), 21'h1FFFFF);
    redirect_valid = 0;
    tick(); check_id("t6.wrap", 1, 16'h0055, 0, 0, 32'hFFFF_FFFF, 0);
    check("t6.addr0", 64'(imem_addr), 0);
    redirect_valid = 1; redirect_pc = 3;
    tick(); redirect_valid = 0;
    tick(); check_id("t6.pre", 1, 16'h0044, 0, 0, 3, 4);
    tick(); check("t6.simm_v", 64'(if_id_valid), 0); check("t6.simm_hold", 64'(if_id_instr), 16'h0044);
    reset = 0;
    tick(); check_id("t6.rst", 0, 0, 0, 0, 0, 0); check("t6.rst_addr", 64'(imem_addr), 0);
    reset = 1;
    tick(); check_id("t6.sop", 1, 16'h0011, 0, 0, 0, 1);
`ifdef FETCH_PERF_EN
    check("perf.instr", 64'(perf_instr_cnt), 1);
    check("perf.bubble", 64'(perf_bubble_cnt), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
